// File: rtl/m1_trace_buffer.sv
// Instruction trace buffer for the i8080 core: captures {pc,sp,regs} on every M1
// fetch into a circular RAM, with PC trigger, post-trigger window and step limit.
module m1_trace_buffer #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned STEP_LIMIT = 1000,
    parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m1_strobe,
    input  logic [15:0]   pc,
    input  logic [15:0]   sp,
    input  logic [63:0]   regs,
    input  logic          arm,
    input  logic          trig_en,
    input  logic [15:0]   trig_pc,
    input  logic [CW-1:0] post_count,
    input  logic          rd_en,
    output logic [95:0]   rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count,
    output logic          triggered,
    output logic          done,
    output logic          overflow,
    output logic          halt_req
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = (STEP_LIMIT > 0) ? $clog2(STEP_LIMIT + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STEP_LIMIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] post_rem_q, post_rem_d;
    logic [SW-1:0] step_q, step_d;
    logic          triggered_q, triggered_d;
    logic          overflow_q, overflow_d;
    logic          halt_q, halt_d;
    logic          done_q, done_d;
    logic          rd_valid_q, rd_valid_d;
    logic [95:0]   rd_data_q;
    logic          wr_en_c, rd_fire_c, limit_hit_c;
    logic [CW-1:0] post_clamp_c;

    logic [95:0] mem [DEPTH];

    // Next-state and capture control
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        post_rem_d   = post_rem_q;
        step_d       = step_q;
        triggered_d  = triggered_q;
        overflow_d   = overflow_q;
        halt_d       = halt_q;
        rd_valid_d   = 1'b0;
        wr_en_c      = 1'b0;
        rd_fire_c    = 1'b0;
        limit_hit_c  = 1'b0;
        post_clamp_c = (post_count > DEPTH_C) ? DEPTH_C : post_count;

        if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_rem_d  = '0;
            step_d      = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
            halt_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    if (m1_strobe) begin
                        wr_en_c  = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        // Full buffer: overwrite oldest and drag the read pointer along
                        if (count_q == DEPTH_C) begin
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                        if (STEP_LIMIT != 0) begin
                            step_d      = step_q + 1'b1;
                            limit_hit_c = (step_d == LIMIT_C);
                        end
                        if (state_q == ST_ARMED) begin
                            if (!trig_en || (pc == trig_pc)) begin
                                triggered_d = 1'b1;
                                post_rem_d  = post_clamp_c;
                                state_d     = (post_clamp_c == '0) ? ST_DONE : ST_POST;
                            end
                        end else begin
                            post_rem_d = post_rem_q - 1'b1;
                            if (post_rem_d == '0) begin
                                state_d = ST_DONE;
                            end
                        end
                        if (limit_hit_c) begin
                            state_d = ST_DONE;
                            halt_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_en && (count_q != '0)) begin
                        rd_fire_c  = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        count_d    = count_q - 1'b1;
                        rd_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_rem_q  <= '0;
            step_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            halt_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_rem_q  <= post_rem_d;
            step_q      <= step_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            halt_q      <= halt_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Snapshot storage: one write port, contents not reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q] <= {pc, sp, regs};
        end
    end

    // Registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_fire_c) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign halt_req  = halt_q;

endmodule
